// File: rtl/updown_pkg.sv
// Shared mode encoding for the up/down counter family.
package updown_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_SAT    = 2'b00;
   localparam mode_t MODE_WRAP   = 2'b01;
   localparam mode_t MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/updown_next.sv
// Combinational next-step logic for an in-range count: saturate, wrap or bounce.
module updown_next
   import updown_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             dir,
   input  logic             bdir,
   input  mode_t            mode,
   output logic [WIDTH-1:0] next_count,
   output logic             next_bdir,
   output logic             evt
);

   always_comb begin
      next_count = count;
      next_bdir  = bdir;
      evt        = 1'b0;
      case (mode)
         MODE_WRAP: begin
            if (dir) begin
               if (count == hi) begin
                  next_count = lo;
                  evt        = 1'b1;
               end else begin
                  next_count = count + 1'b1;
               end
            end else begin
               if (count == lo) begin
                  next_count = hi;
                  evt        = 1'b1;
               end else begin
                  next_count = count - 1'b1;
               end
            end
         end
         MODE_BOUNCE: begin
            // A single-value range turns in place every step.
            if (bdir) begin
               if (count == hi) begin
                  next_count = (lo == hi) ? hi : hi - 1'b1;
                  next_bdir  = 1'b0;
                  evt        = 1'b1;
               end else begin
                  next_count = count + 1'b1;
               end
            end else begin
               if (count == lo) begin
                  next_count = (lo == hi) ? lo : lo + 1'b1;
                  next_bdir  = 1'b1;
                  evt        = 1'b1;
               end else begin
                  next_count = count - 1'b1;
               end
            end
         end
         default: begin
            if (dir) begin
               if (count < hi) next_count = count + 1'b1;
            end else begin
               if (count > lo) next_count = count - 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with run-time limits; holds registers, priority, clamp and flags.
module param_updown_counter
   import updown_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_lo,
   output logic             at_hi,
   output logic             wrap_pulse,
   output logic             bdir,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d, step_count, load_clamped;
   logic             bdir_q, bdir_d, step_bdir, step_evt;
   logic             pulse_q, pulse_d;

   updown_next #(.WIDTH(WIDTH)) u_next (
      .count      (count_q),
      .lo         (lo),
      .hi         (hi),
      .dir        (dir),
      .bdir       (bdir_q),
      .mode       (mode_t'(mode)),
      .next_count (step_count),
      .next_bdir  (step_bdir),
      .evt        (step_evt)
   );

   assign cfg_err = (lo > hi);

   always_comb begin
      load_clamped = load_val;
      if (load_val < lo)      load_clamped = lo;
      else if (load_val > hi) load_clamped = hi;
   end

   always_comb begin
      count_d = count_q;
      bdir_d  = bdir_q;
      pulse_d = 1'b0;
      if (cfg_err) begin
         count_d = count_q;
      end else if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         // Limits may have moved under the count; pull it back in first.
         if (count_q < lo) begin
            count_d = lo;
         end else if (count_q > hi) begin
            count_d = hi;
         end else begin
            count_d = step_count;
            bdir_d  = step_bdir;
            pulse_d = step_evt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_COUNT;
         bdir_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         count_q <= count_d;
         bdir_q  <= bdir_d;
         pulse_q <= pulse_d;
      end
   end

   assign count      = count_q;
   assign bdir       = bdir_q;
   assign wrap_pulse = pulse_q;
   assign at_lo      = (count_q == lo);
   assign at_hi      = (count_q == hi);

endmodule

// File: tb/tb_param_updown_counter.sv
// Table-driven check of param_updown_counter with WIDTH = 3 (second instance RESET_VAL = 6).
module tb_param_updown_counter;

   localparam int W = 3;

   typedef struct {
      logic         rst;
      logic         en;
      logic         dir;
      logic [1:0]   mode;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ld;
      logic [W-1:0] lv;
      logic [W-1:0] e_cnt;
      logic         e_alo;
      logic         e_ahi;
      logic         e_pls;
      logic         e_bdir;
      logic         e_cerr;
   } vec_t;

   vec_t vecs[$];

   logic         clk = 1'b0;
   logic         reset, en, dir, load;
   logic [1:0]   mode;
   logic [W-1:0] lo, hi, load_val;
   logic [W-1:0] count, count6;
   logic         at_lo, at_hi, wrap_pulse, bdir, cfg_err;
   logic         at_lo6, at_hi6, wrap_pulse6, bdir6, cfg_err6;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
      .lo(lo), .hi(hi), .load(load), .load_val(load_val),
      .count(count), .at_lo(at_lo), .at_hi(at_hi),
      .wrap_pulse(wrap_pulse), .bdir(bdir), .cfg_err(cfg_err)
   );

   param_updown_counter #(.WIDTH(W), .RESET_VAL(6)) dut6 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
      .lo(lo), .hi(hi), .load(load), .load_val(load_val),
      .count(count6), .at_lo(at_lo6), .at_hi(at_hi6),
      .wrap_pulse(wrap_pulse6), .bdir(bdir6), .cfg_err(cfg_err6)
   );

   function automatic void add(input logic r, input logic e, input logic d,
                               input logic [1:0] m, input logic [W-1:0] l,
                               input logic [W-1:0] h, input logic ldv,
                               input logic [W-1:0] v, input logic [W-1:0] c,
                               input logic alo, input logic ahi, input logic p,
                               input logic b, input logic ce);
      vecs.push_back('{r, e, d, m, l, h, ldv, v, c, alo, ahi, p, b, ce});
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00;
      lo = '0; hi = 3'd7; load = 1'b0; load_val = '0;

      //   rst en dir mode lo hi ld lv | cnt alo ahi pls bdir cerr
      add(1, 0, 0, 0, 0, 7, 0, 0,  0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 7, 1, 5,  5, 0, 0, 0, 1, 0);
      add(1, 1, 1, 1, 0, 7, 1, 3,  0, 1, 0, 0, 1, 0);
      // saturate up, ten enabled cycles
      add(0, 1, 1, 0, 0, 7, 0, 0,  1, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  2, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  3, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  4, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  5, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  6, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  7, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  7, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  7, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 7, 0, 0,  7, 0, 1, 0, 1, 0);
      // mode 11 saturates down and holds at lo
      add(0, 1, 0, 3, 5, 7, 0, 0,  6, 0, 0, 0, 1, 0);
      add(0, 1, 0, 3, 5, 7, 0, 0,  5, 1, 0, 0, 1, 0);
      add(0, 1, 0, 3, 5, 7, 0, 0,  5, 1, 0, 0, 1, 0);
      // wrap lo=2 hi=5
      add(0, 0, 0, 1, 2, 5, 1, 3,  3, 0, 0, 0, 1, 0);
      add(0, 1, 0, 1, 2, 5, 0, 0,  2, 1, 0, 0, 1, 0);
      add(0, 1, 0, 1, 2, 5, 0, 0,  5, 0, 1, 1, 1, 0);
      add(0, 1, 0, 1, 2, 5, 0, 0,  4, 0, 0, 0, 1, 0);
      add(0, 1, 1, 1, 2, 5, 0, 0,  5, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 2, 5, 0, 0,  2, 1, 0, 1, 1, 0);
      // bounce lo=1 hi=3, dir input scrambled
      add(0, 0, 0, 2, 1, 3, 1, 1,  1, 1, 0, 0, 1, 0);
      add(0, 1, 0, 2, 1, 3, 0, 0,  2, 0, 0, 0, 1, 0);
      add(0, 1, 1, 2, 1, 3, 0, 0,  3, 0, 1, 0, 1, 0);
      add(0, 1, 1, 2, 1, 3, 0, 0,  2, 0, 0, 1, 0, 0);
      add(0, 1, 0, 2, 1, 3, 0, 0,  1, 1, 0, 0, 0, 0);
      add(0, 1, 0, 2, 1, 3, 0, 0,  2, 0, 0, 1, 1, 0);
      // load clamp, load beats en, run-time limit clamps
      add(0, 0, 0, 0, 0, 4, 1, 6,  4, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 4, 1, 1,  1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 4, 1, 4,  4, 0, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 2, 0, 0,  2, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 3, 6, 0, 0,  3, 1, 0, 0, 1, 0);
      // cfg_err holds under en and load, then recovery
      add(0, 1, 1, 1, 5, 2, 0, 0,  3, 0, 0, 0, 1, 1);
      add(0, 1, 0, 1, 5, 2, 1, 0,  3, 0, 0, 0, 1, 1);
      add(0, 1, 1, 1, 0, 2, 0, 0,  2, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 0, 2, 0, 0,  0, 1, 0, 1, 1, 0);
      // lo == hi in bounce, wrap, saturate
      add(0, 1, 1, 2, 4, 4, 0, 0,  4, 1, 1, 0, 1, 0);
      add(0, 1, 1, 2, 4, 4, 0, 0,  4, 1, 1, 1, 0, 0);
      add(0, 1, 1, 2, 4, 4, 0, 0,  4, 1, 1, 1, 1, 0);
      add(0, 1, 0, 1, 4, 4, 0, 0,  4, 1, 1, 1, 1, 0);
      add(0, 1, 1, 0, 4, 4, 0, 0,  4, 1, 1, 0, 1, 0);
      // bdir survives a mode change
      add(0, 1, 1, 2, 4, 4, 0, 0,  4, 1, 1, 1, 0, 0);
      add(0, 1, 1, 0, 4, 4, 0, 0,  4, 1, 1, 0, 0, 0);
      add(0, 1, 1, 2, 0, 7, 0, 0,  3, 0, 0, 0, 0, 0);
      // full-range wrap, hold, reset right after a pulse
      add(0, 0, 1, 1, 0, 7, 1, 7,  7, 0, 1, 0, 0, 0);
      add(0, 1, 1, 1, 0, 7, 0, 0,  0, 1, 0, 1, 0, 0);
      add(0, 0, 1, 1, 0, 7, 0, 0,  0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 7, 0, 0,  7, 0, 1, 1, 0, 0);
      add(1, 1, 1, 0, 2, 5, 0, 0,  0, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 2, 5, 0, 0,  2, 1, 0, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset    = vecs[i].rst;
         en       = vecs[i].en;
         dir      = vecs[i].dir;
         mode     = vecs[i].mode;
         lo       = vecs[i].lo;
         hi       = vecs[i].hi;
         load     = vecs[i].ld;
         load_val = vecs[i].lv;
         @(posedge clk);
         #1;
         chk("count",      i, int'(count),      int'(vecs[i].e_cnt));
         chk("at_lo",      i, int'(at_lo),      int'(vecs[i].e_alo));
         chk("at_hi",      i, int'(at_hi),      int'(vecs[i].e_ahi));
         chk("wrap_pulse", i, int'(wrap_pulse), int'(vecs[i].e_pls));
         chk("bdir",       i, int'(bdir),       int'(vecs[i].e_bdir));
         chk("cfg_err",    i, int'(cfg_err),    int'(vecs[i].e_cerr));
         if (vecs[i].rst) begin
            chk("count_rv6",  i, int'(count6),      6);
            chk("pulse_rv6",  i, int'(wrap_pulse6), 0);
            chk("bdir_rv6",   i, int'(bdir6),       1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
